bayer_pattern_gen: RTL and testbench
====================================

BAYER_PATTERN_GEN -- requirements
Module: bayer_pattern_gen

Interface
REQ-001 Parameter bits, default 8, pixel width in bits.
REQ-002 Parameter width, default 2048, active pixels per line.
REQ-003 Parameter height, default 2048, active lines per frame.
REQ-004 Parameter hBlank, default 16, idle cycles after each active line.
REQ-005 Parameter vBlank, default 4, idle cycles between vsync pulse and first line.
REQ-006 Parameter vsyncLen, default 2, vsync pulse length in cycles.
REQ-007 Parameter bayerFormat, default 0, 2-bit CFA phase of pixel (0,0).
REQ-008 clk  input  1  sole clock, all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 enable_i  input  1  start and continue frame generation.
REQ-011 pattern_sel_i  input  2  pattern select.
REQ-012 flat_i  input  bits  value for flat pattern.
REQ-013 defect_period_i  input  16  defect injection period, 0 = off.
REQ-014 href_o  output  1  active-pixel qualifier.
REQ-015 vsync_o  output  1  frame-start pulse.
REQ-016 pixel_o  output  bits  pixel data.
REQ-017 defect_flag_o  output  1  high on cycles carrying an injected defect.
REQ-018 frame_done_o  output  1  one-cycle pulse after last HBLANK of a frame.

Function
REQ-019 FSM states SHALL be IDLE, VSYNC, VBP, ACTIVE, HBLANK.
- IDLE -> VSYNC when enable_i=1.
- VSYNC: vsyncLen cycles, vsync_o=1 -> VBP.
- VBP: vBlank cycles -> ACTIVE.
- ACTIVE: width cycles, href_o=1 -> HBLANK.
- HBLANK: hBlank cycles -> ACTIVE, or after line height-1 -> VSYNC if enable_i=1, else IDLE.
REQ-020 All outputs SHALL be registered; pixel_o, defect_flag_o and href_o SHALL change in the same cycle.
REQ-021 pixel_o SHALL be 0 whenever href_o=0.
REQ-022 Column x (0..width-1) and line y (0..height-1) counters SHALL wrap to 0 at the end of the line and of the frame respectively; an 8-bit frame counter f SHALL increment at each frame_done_o and wrap from 255 to 0.
REQ-023 pattern_sel_i, flat_i and defect_period_i SHALL be sampled on entry to VSYNC and held for the whole frame.
REQ-024 Patterns, truncated to bits:
- 0: flat_i.
- 1: x.
- 2: ch=bayerFormat^{y[0],x[0]}, value (ch+1)<<(bits-3).
- 3: x+y+f.
REQ-025 Deasserting enable_i mid-frame SHALL NOT truncate the frame; the generator finishes the frame, then goes to IDLE.
REQ-026 frame_done_o SHALL pulse in the cycle after the last HBLANK cycle of line height-1.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE and clear all counters, the frame counter and the sampled settings.
REQ-028 During rst, href_o, vsync_o, pixel_o, defect_flag_o and frame_done_o SHALL be 0; a frame interrupted by reset SHALL be abandoned, not resumed.

Configuration
REQ-029 Macro DPC_DEFECT_INJECT_EN defined: an active-pixel counter SHALL run across the frame and reset at VSYNC. When the sampled period P≠0 and the counter equals P-1, pixel_o SHALL be all ones and defect_flag_o=1, and the counter SHALL reset to 0.
REQ-030 Macro DPC_DEFECT_INJECT_EN undefined: ports remain, defect_period_i is ignored and defect_flag_o is tied to 0.

Verification (width=8, height=4, hBlank=3, vBlank=2, vsyncLen=2, bits=8)
REQ-031 enable_i=1 from reset release -> vsync_o high 2 cycles; after 2 VBP cycles, 4 href_o bursts of 8 cycles separated by 3 idle cycles; frame_done_o pulses once; total frame 2+2+4*(8+3)=48 cycles.
REQ-032 pattern_sel_i=1 -> every line outputs 0,1,...,7; pattern_sel_i=2, bayerFormat=0 -> line 0 outputs 32,64,32,64..., line 1 outputs 96,128,....
REQ-033 pattern_sel_i=3 over 3 consecutive frames -> first pixel of each frame equals 0, 1, 2.
REQ-034 enable_i dropped at line 1 -> frame completes all 4 lines, frame_done_o pulses, then IDLE with all outputs 0.
REQ-035 rst pulsed during ACTIVE of line 2 -> outputs 0 next cycle; with enable_i=1 the next frame restarts with vsync_o and x=y=0.
REQ-036 With DPC_DEFECT_INJECT_EN defined, defect_period_i=5, pattern_sel_i=0, flat_i=16 -> active pixels 5,10,15,... of the frame are 255 with defect_flag_o=1, all others 16; without the macro, no 255 values appear.

Source files
------------

// File: rtl/bayer_pattern_gen.sv
// Purpose : raster test-pattern source (flat / ramp / Bayer CFA / diagonal), optional defect injection.
// Latency : all outputs registered; href_o, pixel_o and defect_flag_o move together, one clock after state change.
// Backpres: none -- free-running timing once enabled; enable_i only gates the start of the next frame.
//
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-high reset
//   enable_i           - start/continue frame generation (sampled at frame boundaries)
//   pattern_sel_i      - 0 flat, 1 column ramp, 2 Bayer channel code, 3 x+y+frame
//   flat_i             - value for the flat pattern
//   defect_period_i    - inject a saturated pixel every N active pixels (0 = off)
//   href_o, vsync_o    - active-pixel qualifier, frame-start pulse
//   pixel_o            - pixel data, 0 outside active video
//   defect_flag_o      - marks cycles carrying an injected defect
//   frame_done_o       - one-cycle pulse after the final blanking of a frame
// Optional feature: define DPC_DEFECT_INJECT_EN to enable defect injection.
module bayer_pattern_gen #(
  parameter int         bits        = 8,
  parameter int         width       = 2048,
  parameter int         height      = 2048,
  parameter int         hBlank      = 16,
  parameter int         vBlank      = 4,
  parameter int         vsyncLen    = 2,
  parameter logic [1:0] bayerFormat = 2'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  input  logic [1:0]      pattern_sel_i,
  input  logic [bits-1:0] flat_i,
  input  logic [15:0]     defect_period_i,
  output logic            href_o,
  output logic            vsync_o,
  output logic [bits-1:0] pixel_o,
  output logic            defect_flag_o,
  output logic            frame_done_o
);

  localparam int XW = (width  > 1) ? $clog2(width)  : 1;
  localparam int YW = (height > 1) ? $clog2(height) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(height - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_cnt;
  logic [XW-1:0]   r_x;        // column currently on pixel_o
  logic [YW-1:0]   r_y;        // line currently (or last) on pixel_o
  logic [7:0]      r_f;
  logic [1:0]      r_sel;
  logic [bits-1:0] r_flat;

  logic            w_emit;
  logic            w_enter_vsync;
  logic            w_frame_end;
  logic [XW-1:0]   w_nx;
  logic [YW-1:0]   w_ny;
  logic [1:0]      w_ch;
  logic [bits-1:0] w_pat;
  logic            w_defect;

  always_comb begin
    w_next_state = r_state;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE:   if (enable_i) w_next_state = VSYNC;
      VSYNC:  if (r_cnt == 16'(vsyncLen - 1)) w_next_state = VBP;
      VBP:    if (r_cnt == 16'(vBlank - 1)) w_next_state = ACTIVE;
      ACTIVE: if (r_x == X_LAST) w_next_state = HBLANK;
      HBLANK: begin
        if (r_cnt == 16'(hBlank - 1)) begin
          if (r_y == Y_LAST) begin
            w_frame_end  = 1'b1;
            w_next_state = enable_i ? VSYNC : IDLE;
          end else begin
            w_next_state = ACTIVE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_emit        = (w_next_state == ACTIVE);
  assign w_enter_vsync = (w_next_state == VSYNC) && (r_state != VSYNC);

  // Coordinates of the pixel being launched this edge: a fresh line starts at
  // column 0, and leaving HBLANK moves to the following line.
  assign w_nx = (r_state == ACTIVE) ? r_x + XW'(1) : '0;
  assign w_ny = (r_state == HBLANK) ? r_y + YW'(1) : r_y;
  assign w_ch = bayerFormat ^ {w_ny[0], w_nx[0]};

  always_comb begin
    w_pat = '0;
    case (r_sel)
      2'd0:    w_pat = r_flat;
      2'd1:    w_pat = bits'(w_nx);
      2'd2:    w_pat = bits'((32'(w_ch) + 32'd1) << (bits - 3));
      default: w_pat = bits'(32'(w_nx) + 32'(w_ny) + 32'(r_f));
    endcase
  end

`ifdef DPC_DEFECT_INJECT_EN
  logic [15:0] r_period;
  logic [15:0] r_dcnt;
  logic        r_defect_flag;

  assign w_defect = (r_period != 16'd0) && (r_dcnt == r_period - 16'd1);

  // Active-pixel counter spans the whole frame, not each line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period      <= '0;
      r_dcnt        <= '0;
      r_defect_flag <= 1'b0;
    end else begin
      r_defect_flag <= w_emit && w_defect;
      if (w_enter_vsync) begin
        r_period <= defect_period_i;
        r_dcnt   <= '0;
      end else if (w_emit) begin
        r_dcnt <= w_defect ? 16'd0 : r_dcnt + 16'd1;
      end
    end
  end

  assign defect_flag_o = r_defect_flag;
`else
  logic w_unused_defect;
  assign w_unused_defect = ^defect_period_i;
  assign w_defect        = 1'b0;
  assign defect_flag_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_f          <= '0;
      r_sel        <= '0;
      r_flat       <= '0;
      href_o       <= 1'b0;
      vsync_o      <= 1'b0;
      pixel_o      <= '0;
      frame_done_o <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= (w_next_state != r_state) ? 16'd0 : r_cnt + 16'd1;
      href_o       <= w_emit;
      vsync_o      <= (w_next_state == VSYNC);
      pixel_o      <= w_emit ? (w_defect ? '1 : w_pat) : '0;
      frame_done_o <= w_frame_end;
      if (w_frame_end) r_f <= r_f + 8'd1;
      if (w_enter_vsync) begin
        r_sel  <= pattern_sel_i;
        r_flat <= flat_i;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_emit) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
    end
  end

endmodule

// File: tb/tb_bayer_pattern_gen.sv
module tb_bayer_pattern_gen;
  localparam int BITS = 8;
  localparam int W    = 8;
  localparam int H    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable_i;
  logic [1:0]      pattern_sel_i;
  logic [BITS-1:0] flat_i;
  logic [15:0]     defect_period_i;
  logic            href_o;
  logic            vsync_o;
  logic [BITS-1:0] pixel_o;
  logic            defect_flag_o;
  logic            frame_done_o;

  bayer_pattern_gen #(
    .bits(BITS), .width(W), .height(H), .hBlank(3), .vBlank(2), .vsyncLen(2), .bayerFormat(2'd0)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .pattern_sel_i(pattern_sel_i),
    .flat_i(flat_i), .defect_period_i(defect_period_i), .href_o(href_o),
    .vsync_o(vsync_o), .pixel_o(pixel_o), .defect_flag_o(defect_flag_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         failures  = 0;
  logic [8:0] exp_q[$];
  int         tb_f      = 0;
  int         href_seen = 0;
  int         flag_seen = 0;

  function automatic logic [7:0] model_pix(int sel, logic [7:0] flat, int x, int y, int f);
    case (sel)
      0: return flat;
      1: return 8'(x);
      2: begin
        if (y % 2 == 0) return (x % 2 == 0) ? 8'd32 : 8'd64;
        else            return (x % 2 == 0) ? 8'd96 : 8'd128;
      end
      default: return 8'((x + y + f) % 256);
    endcase
  endfunction

  task automatic push_frame(int sel, logic [7:0] flat, int period, int f);
    int         n;
    logic [7:0] pix;
    logic       flag;
    n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n++;
        pix  = model_pix(sel, flat, x, y, f);
        flag = 1'b0;
`ifdef DPC_DEFECT_INJECT_EN
        if (period != 0 && n % period == 0) begin
          pix  = 8'hFF;
          flag = 1'b1;
        end
`else
        if (period < 0) flag = 1'b0;
`endif
        exp_q.push_back({flag, pix});
      end
    end
  endtask

  // One clock: sample outputs mid-cycle and retire active pixels against the scoreboard.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (rst) tb_f = 0;
    else if (frame_done_o) tb_f++;
    if (defect_flag_o) flag_seen++;
    checks++;
    if (href_o) begin
      href_seen++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pixel got=%0d expected=no_pixel", pixel_o);
      end else begin
        e = exp_q.pop_front();
        if ({defect_flag_o, pixel_o} !== e) begin
          failures++;
          $display("FAIL sb_pixel got flag=%0b pix=%0d expected flag=%0b pix=%0d",
                   defect_flag_o, pixel_o, e[8], e[7:0]);
        end
      end
    end else if (pixel_o !== 8'd0 || defect_flag_o !== 1'b0) begin
      failures++;
      $display("FAIL blank_zero got pix=%0d flag=%0b expected 0", pixel_o, defect_flag_o);
    end
  endtask

  task automatic wait_frame_done(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (frame_done_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b0; pattern_sel_i = 2'd0; flat_i = 8'd0; defect_period_i = 16'd0;
    repeat (3) step();
    checks++;
    if ({href_o, vsync_o, pixel_o, defect_flag_o, frame_done_o} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h expected=0", {href_o, vsync_o, pixel_o, defect_flag_o, frame_done_o});
    end
    enable_i = 1'b1;
    repeat (2) step();
    checks++;
    if (vsync_o !== 1'b0 || href_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_dominates_enable got vsync=%0b href=%0b expected 0 0", vsync_o, href_o);
    end
  endtask

  task automatic test_frame_timing();
    bit vs, hr, fd;
    int t;
    pattern_sel_i = 2'd1;
    push_frame(1, 8'd0, 0, 0);
    rst = 1'b0;
    for (int s = 1; s <= 49; s++) begin
      step();
      t  = s - 5;
      vs = (s <= 2);
      hr = (t >= 0) && (t < 44) && (t % 11 < 8);
      fd = (s == 49);
      checks++;
      if ({vsync_o, href_o, frame_done_o} !== {vs, hr, fd}) begin
        failures++;
        $display("FAIL timing cycle=%0d got vs/href/done=%0b%0b%0b expected %0b%0b%0b",
                 s, vsync_o, href_o, frame_done_o, vs, hr, fd);
      end
      if (s == 40) enable_i = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timing_pixels_left got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_pattern_bayer();
    bit ok;
    pattern_sel_i = 2'd2; flat_i = 8'h5A; defect_period_i = 16'd0;
    push_frame(2, 8'h5A, 0, tb_f);
    enable_i = 1'b1;
    step();
    // Inputs changed mid-frame must not affect the frame in flight.
    enable_i = 1'b0; pattern_sel_i = 2'd1; flat_i = 8'hFF; defect_period_i = 16'd3;
    wait_frame_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bayer_frame_done got=timeout expected=pulse"); end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bayer_pixels_left got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base;
    pattern_sel_i = 2'd0; flat_i = 8'h3C; defect_period_i = 16'd0;
    push_frame(0, 8'h3C, 0, tb_f);
    base = href_seen;
    enable_i = 1'b1;
    for (int i = 0; i < 100 && href_seen - base < 10; i++) step();
    enable_i = 1'b0;
    wait_frame_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL drop_frame_done got=timeout expected=pulse"); end
    checks++;
    if (href_seen - base != W * H) begin
      failures++;
      $display("FAIL drop_pixel_count got=%0d expected=%0d", href_seen - base, W * H);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({vsync_o, href_o, frame_done_o} !== 3'b000) begin
        failures++;
        $display("FAIL drop_idle cycle=%0d got=%0b expected=000", i, {vsync_o, href_o, frame_done_o});
      end
    end
  endtask

  task automatic test_pattern_sum();
    int  dcount, idx;
    bit  want_first;
    rst = 1'b1; enable_i = 1'b0;
    step(); step();
    exp_q.delete();
    rst = 1'b0; pattern_sel_i = 2'd3; defect_period_i = 16'd0;
    for (int k = 0; k < 3; k++) push_frame(3, 8'd0, 0, k);
    enable_i = 1'b1;
    dcount = 0; idx = 0; want_first = 1'b0;
    for (int i = 0; i < 300 && dcount < 3; i++) begin
      step();
      if (vsync_o) want_first = 1'b1;
      else if (want_first && href_o) begin
        want_first = 1'b0;
        checks++;
        if (pixel_o !== 8'(idx)) begin
          failures++;
          $display("FAIL sum_first_pixel frame=%0d got=%0d expected=%0d", idx, pixel_o, idx);
        end
        idx++;
      end
      if (frame_done_o) begin
        dcount++;
        if (dcount == 2) enable_i = 1'b0;
      end
    end
    checks++;
    if (dcount != 3 || idx != 3) begin
      failures++;
      $display("FAIL sum_frames got done=%0d firsts=%0d expected 3 3", dcount, idx);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sum_pixels_left got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int base;
    pattern_sel_i = 2'd1;
    push_frame(1, 8'd0, 0, tb_f);
    base = href_seen;
    enable_i = 1'b1;
    for (int i = 0; i < 200 && href_seen - base < 19; i++) step();
    checks++;
    if (href_o !== 1'b1) begin failures++; $display("FAIL midrst_in_active got href=%0b expected=1", href_o); end
    rst = 1'b1;
    step();
    checks++;
    if ({href_o, vsync_o, pixel_o, defect_flag_o, frame_done_o} !== 12'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%0h expected=0", {href_o, vsync_o, pixel_o, defect_flag_o, frame_done_o});
    end
    exp_q.delete();
    rst = 1'b0;
    push_frame(1, 8'd0, 0, 0);
    step();
    checks++;
    if (vsync_o !== 1'b1) begin failures++; $display("FAIL midrst_restart_vsync got=%0b expected=1", vsync_o); end
    enable_i = 1'b0;
    wait_frame_done(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_frame got done=%0b left=%0d expected 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_defect();
    bit ok;
    int base, exp_flags;
    for (int pass = 0; pass < 2; pass++) begin
      pattern_sel_i = 2'd0; flat_i = 8'd16;
      defect_period_i = (pass == 0) ? 16'd5 : 16'd0;
`ifdef DPC_DEFECT_INJECT_EN
      exp_flags = (pass == 0) ? (W * H) / 5 : 0;
`else
      exp_flags = 0;
`endif
      push_frame(0, 8'd16, (pass == 0) ? 5 : 0, tb_f);
      base = flag_seen;
      enable_i = 1'b1;
      step();
      enable_i = 1'b0;
      wait_frame_done(100, ok);
      checks++;
      if (!ok || flag_seen - base != exp_flags) begin
        failures++;
        $display("FAIL defect_count pass=%0d got done=%0b flags=%0d expected 1 %0d",
                 pass, ok, flag_seen - base, exp_flags);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL defect_pixels_left got=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_pattern_bayer();
    test_enable_drop();
    test_pattern_sum();
    test_reset_mid_frame();
    test_defect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
